// File: rtl/ctrl_pulse_monitor.sv
// Periodic control-input monitor: synchronizes i_ctrl, measures period and high
// time in clock cycles, flags lock on two equal periods and a sticky timeout.
`timescale 1ns/1ps
module ctrl_pulse_monitor #(
    parameter int CNT_W   = 8,
    parameter int TIMEOUT = 200
) (
    input  logic             clock,
    input  logic             reset_n,
    input  logic             i_ctrl,
    output logic [CNT_W-1:0] o_period,
    output logic [CNT_W-1:0] o_high,
    output logic             o_valid,
    output logic             o_locked,
    output logic             o_timeout
);

    // state | meaning
    // IDLE  | no measurement running; wait for a rise to start one
    // HIGH  | counting the high phase; fall captures the high time
    // LOW   | counting the low phase; rise closes and reports the period
    typedef enum logic [1:0] {IDLE, HIGH, LOW} state_t;

    localparam logic [CNT_W-1:0] TO_VAL  = CNT_W'(TIMEOUT);
    localparam logic [CNT_W-1:0] CNT_MAX = '1;
    localparam logic [CNT_W-1:0] ONE     = CNT_W'(1);

    logic             s0_q, s1_q, sd_q;
    logic             rise, fall;
    state_t           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d, cnt_inc;
    logic [CNT_W-1:0] high_cap_q, high_cap_d;
    logic             have_prev_q, have_prev_d;
    logic [CNT_W-1:0] period_q, period_d;
    logic [CNT_W-1:0] high_q, high_d;
    logic             valid_q, valid_d;
    logic             locked_q, locked_d;
    logic             timeout_q, timeout_d;
    logic             to_hit;

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            s0_q <= 1'b0;
            s1_q <= 1'b0;
            sd_q <= 1'b0;
        end else begin
            s0_q <= i_ctrl;
            s1_q <= s0_q;
            sd_q <= s1_q;
        end
    end

    assign rise    = s1_q & ~sd_q;
    assign fall    = ~s1_q & sd_q;
    assign cnt_inc = (cnt_q == CNT_MAX) ? cnt_q : cnt_q + ONE;

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        high_cap_d  = high_cap_q;
        have_prev_d = have_prev_q;
        period_d    = period_q;
        high_d      = high_q;
        valid_d     = 1'b0;
        locked_d    = locked_q;
        timeout_d   = timeout_q;
        to_hit      = 1'b0;

        case (state_q)
            IDLE: begin
                cnt_d = '0;
                if (rise) begin
                    cnt_d   = ONE;
                    state_d = HIGH;
                end
            end
            HIGH: begin
                cnt_d = cnt_inc;
                if (fall) begin
                    high_cap_d = cnt_q;
                    state_d    = LOW;
                end else if (cnt_q == TO_VAL) begin
                    to_hit = 1'b1;
                end
            end
            LOW: begin
                cnt_d = cnt_inc;
                if (rise) begin
                    period_d    = cnt_q;
                    high_d      = high_cap_q;
                    valid_d     = 1'b1;
                    locked_d    = have_prev_q & (cnt_q == period_q);
                    have_prev_d = 1'b1;
                    timeout_d   = 1'b0;
                    cnt_d       = ONE;
                    state_d     = HIGH;
                end else if (cnt_q == TO_VAL) begin
                    to_hit = 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase

        // An edge in the same cycle always takes priority, so to_hit implies no edge.
        if (to_hit) begin
            timeout_d   = 1'b1;
            locked_d    = 1'b0;
            have_prev_d = 1'b0;
            cnt_d       = '0;
            state_d     = IDLE;
        end
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_q     <= IDLE;
            cnt_q       <= '0;
            high_cap_q  <= '0;
            have_prev_q <= 1'b0;
            period_q    <= '0;
            high_q      <= '0;
            valid_q     <= 1'b0;
            locked_q    <= 1'b0;
            timeout_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            high_cap_q  <= high_cap_d;
            have_prev_q <= have_prev_d;
            period_q    <= period_d;
            high_q      <= high_d;
            valid_q     <= valid_d;
            locked_q    <= locked_d;
            timeout_q   <= timeout_d;
        end
    end

    assign o_period  = period_q;
    assign o_high    = high_q;
    assign o_valid   = valid_q;
    assign o_locked  = locked_q;
    assign o_timeout = timeout_q;

endmodule

// File: tb/tb_ctrl_pulse_monitor.sv
// Directed bench for ctrl_pulse_monitor: square-wave streams, period change,
// low/high timeouts, mid-measurement reset and input high at reset release.
`timescale 1ns/1ps
module tb_ctrl_pulse_monitor;

    logic       clock = 1'b0;
    logic       reset_n = 1'b0;
    logic       i_ctrl = 1'b0;
    logic [7:0] o_period, o_high;
    logic       o_valid, o_locked, o_timeout;

    typedef struct packed {
        logic [7:0] p;
        logic [7:0] h;
        logic       l;
        logic       t;
    } rep_t;

    rep_t reps[$];
    int   n_cmp = 0;
    int   n_err = 0;
    int   n_dbl = 0;
    logic prev_v = 1'b0;
    int   base;

    ctrl_pulse_monitor #(.CNT_W(8), .TIMEOUT(200)) dut (
        .clock    (clock),
        .reset_n  (reset_n),
        .i_ctrl   (i_ctrl),
        .o_period (o_period),
        .o_high   (o_high),
        .o_valid  (o_valid),
        .o_locked (o_locked),
        .o_timeout(o_timeout)
    );

    always #5 clock = ~clock;

    // Every report is recorded at the falling edge, away from the update edge.
    always @(negedge clock) begin
        if (o_valid) begin
            reps.push_back({o_period, o_high, o_locked, o_timeout});
            if (prev_v) n_dbl <= n_dbl + 1;
        end
        prev_v <= o_valid;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp)
        else begin
            n_err++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic chk_rep(input string tag, input int idx, input int p, input int h,
                           input int l, input int t);
        rep_t r;
        r = (idx < reps.size()) ? reps[idx] : '1;
        chk({tag, ".period"},  32'(r.p), 32'(p));
        chk({tag, ".high"},    32'(r.h), 32'(h));
        chk({tag, ".locked"},  32'(r.l), 32'(l));
        chk({tag, ".timeout"}, 32'(r.t), 32'(t));
    endtask

    // Inputs change 1 ns after a rising edge and hold for n cycles.
    task automatic drive(input logic v, input int n);
        i_ctrl = v;
        repeat (n) begin
            @(posedge clock);
            #1;
        end
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, ".period"},  32'(o_period),  32'd0);
        chk({tag, ".high"},    32'(o_high),    32'd0);
        chk({tag, ".valid"},   32'(o_valid),   32'd0);
        chk({tag, ".locked"},  32'(o_locked),  32'd0);
        chk({tag, ".timeout"}, 32'(o_timeout), 32'd0);
    endtask

    initial begin
        // Reset state
        repeat (3) @(posedge clock);
        #1;
        chk_all_zero("reset");
        reset_n = 1'b1;
        drive(1'b0, 3);

        // 1: period 20 / high 10 stream, five reports
        base = reps.size();
        for (int i = 0; i < 5; i++) begin
            drive(1'b1, 10);
            drive(1'b0, 10);
        end
        drive(1'b1, 10);
        chk("t1.count", 32'(reps.size() - base), 32'd5);
        chk_rep("t1.r0", base, 20, 10, 0, 0);
        chk_rep("t1.r1", base + 1, 20, 10, 1, 0);
        chk_rep("t1.r4", base + 4, 20, 10, 1, 0);

        // 2: switch to period 12 / high 3
        drive(1'b0, 10);
        base = reps.size();
        for (int i = 0; i < 3; i++) begin
            drive(1'b1, 3);
            drive(1'b0, 9);
        end
        drive(1'b1, 3);
        drive(1'b0, 2);
        chk("t2.count", 32'(reps.size() - base), 32'd4);
        chk_rep("t2.r0", base, 20, 10, 1, 0);
        chk_rep("t2.r1", base + 1, 12, 3, 0, 0);
        chk_rep("t2.r2", base + 2, 12, 3, 1, 0);

        // 3: hold low; timeout lands 200 cycles after the last counted rise
        base = reps.size();
        drive(1'b0, 197);
        chk("t3.timeout_before", 32'(o_timeout), 32'd0);
        chk("t3.locked_before",  32'(o_locked),  32'd1);
        drive(1'b0, 1);
        chk("t3.timeout_at", 32'(o_timeout), 32'd1);
        chk("t3.locked_at",  32'(o_locked),  32'd0);
        chk("t3.no_valid",   32'(reps.size() - base), 32'd0);
        drive(1'b1, 10);
        chk("t3.idle_rise_keeps_timeout", 32'(o_timeout), 32'd1);
        drive(1'b0, 10);
        drive(1'b1, 10);
        drive(1'b0, 10);
        drive(1'b1, 10);
        chk("t3.count", 32'(reps.size() - base), 32'd2);
        chk_rep("t3.r0", base, 20, 10, 0, 0);
        chk_rep("t3.r1", base + 1, 20, 10, 1, 0);

        // 4: hold high past the limit while in HIGH
        base = reps.size();
        drive(1'b1, 192);
        chk("t4.timeout_before", 32'(o_timeout), 32'd0);
        drive(1'b1, 1);
        chk("t4.timeout_at", 32'(o_timeout), 32'd1);
        chk("t4.locked_at",  32'(o_locked),  32'd0);
        chk("t4.period_kept", 32'(o_period), 32'd20);
        chk("t4.high_kept",   32'(o_high),   32'd10);
        chk("t4.no_valid", 32'(reps.size() - base), 32'd0);

        // 5: reset in the middle of a LOW phase
        drive(1'b0, 10);
        drive(1'b1, 10);
        chk("t5.idle_rise_keeps_timeout", 32'(o_timeout), 32'd1);
        drive(1'b0, 5);
        reset_n = 1'b0;
        #2;
        chk_all_zero("t5.async");
        @(posedge clock);
        #1;
        reset_n = 1'b1;
        base = reps.size();
        drive(1'b0, 4);
        drive(1'b1, 10);
        chk("t5.no_partial", 32'(reps.size() - base), 32'd0);
        drive(1'b0, 10);
        drive(1'b1, 10);
        drive(1'b0, 10);
        drive(1'b1, 10);
        chk("t5.count", 32'(reps.size() - base), 32'd2);
        chk_rep("t5.r0", base, 20, 10, 0, 0);
        chk_rep("t5.r1", base + 1, 20, 10, 1, 0);

        // 6: input already high at reset release, period 10 / high 5
        reset_n = 1'b0;
        i_ctrl = 1'b1;
        #2;
        @(posedge clock);
        #1;
        reset_n = 1'b1;
        base = reps.size();
        drive(1'b1, 5);
        for (int i = 0; i < 3; i++) begin
            drive(1'b0, 5);
            drive(1'b1, 5);
        end
        chk("t6.count", 32'(reps.size() - base), 32'd3);
        chk("t6.r0.period", 32'(reps.size() > base ? reps[base].p : 8'hFF), 32'd10);
        chk("t6.r0.high_le5", 32'(reps.size() > base ? (reps[base].h <= 8'd5) : 1'b0), 32'd1);
        chk("t6.r0.locked", 32'(reps.size() > base ? reps[base].l : 1'b1), 32'd0);
        chk_rep("t6.r1", base + 1, 10, 5, 1, 0);
        chk_rep("t6.r2", base + 2, 10, 5, 1, 0);

        chk("valid_single_cycle", 32'(n_dbl), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
